// File: rtl/nn_input_loader.sv
// nn_input_loader: serial fixed_point stream -> one NUM_INPUTS frame for the network.
// Optional partial-frame idle timeout when NN_LOADER_TIMEOUT_EN is defined.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   in_valid/in_ready   : sample handshake; in_data sample, in_last end of frame
//   inputs[]            : assembled frame, index 0 = first sample
//   inputs_ready        : one-cycle start pulse to the network
//   outputs_ready       : network-done pulse, releases the frame
//   busy                : frame issued, network still running
//   frame_error         : one-cycle pulse on short/long/abandoned frame
//   frame_count         : frames issued since reset (wraps)
module nn_input_loader #(
    parameter int NUM_INPUTS     = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DATA_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] inputs [NUM_INPUTS],
    output logic              inputs_ready,
    input  logic              outputs_ready,
    output logic              busy,
    output logic              frame_error,
    output logic [15:0]       frame_count
);

    localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [1:0] {
        FILL,
        DROP,
        ISSUE,
        WAIT_NET
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] count;
    logic          beat;
    logic          fill_beat;
    logic          last_slot;

    assign beat      = in_valid && in_ready;
    assign fill_beat = beat && (state == FILL);
    assign last_slot = (count == CW'(NUM_INPUTS - 1));

`ifdef NN_LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] idle_cnt;
    logic          timeout;

    // Idle time only matters once a frame has started filling.
    assign timeout = (state == FILL) && (count != '0) && !beat
                  && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || state != FILL || count == '0 || beat || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= FILL;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FILL:
                if (fill_beat && last_slot)
                    state_n = in_last ? ISSUE : DROP;
            DROP:
                if (beat && in_last)
                    state_n = FILL;
            ISSUE:
                state_n = WAIT_NET;
            WAIT_NET:
                if (outputs_ready)
                    state_n = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL) || (state == DROP);
    end

    // Registered outputs are loaded from the next state so that
    // inputs_ready/busy line up with ISSUE/WAIT_NET exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            inputs_ready <= 1'b0;
            busy         <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                inputs[i] <= '0;
        end else begin
            inputs_ready <= (state_n == ISSUE);
            busy         <= (state_n == WAIT_NET);
            frame_error  <= 1'b0;
            if (state_n == ISSUE)
                frame_count <= frame_count + 16'd1;
            if (fill_beat) begin
                inputs[count] <= in_data;
                if (last_slot) begin
                    count       <= '0;
                    frame_error <= !in_last;
                end else if (in_last) begin
                    count       <= '0;
                    frame_error <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end else if (state == WAIT_NET && outputs_ready) begin
                count <= '0;
            end
`ifdef NN_LOADER_TIMEOUT_EN
            else if (timeout) begin
                count       <= '0;
                frame_error <= 1'b1;
            end
`endif
        end
    end

endmodule
